port_bus_ctrl: RTL and testbench
================================

# port_bus_ctrl

Request/response transaction controller that sits directly upstream of the bidirectional port interface and drives its `dir` and `to_port` fields while consuming `from_port`. It turns single-beat read/write requests from core logic into timed bus cycles on a cartridge/link-style port. Wait states and a release (turnaround) gap are enforced so the FPGA and the far side never drive the pins simultaneously.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: port and data width.
- `WAIT_CYCLES`, default 2: extra cycles a read or write is held on the bus beyond the minimum 1.
- `TURN_CYCLES`, default 1: cycles after a write with `dir = FROM_PORT` before the next request is accepted; 0 is legal.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller can accept; high only in IDLE.
- `req_write` input 1: 1 = write, 0 = read.
- `req_data` input `DATA_WIDTH`: write data.
- `rsp_valid` output 1: one-cycle completion pulse; no backpressure.
- `rsp_data` output `DATA_WIDTH`: read data, valid with `rsp_valid`; holds last value otherwise.
- `dir` output `port_dir_e`: to port interface `dir`.
- `to_port` output `DATA_WIDTH`: to port interface `to_port`.
- `from_port` input `DATA_WIDTH`: from port interface `from_port`.
- `busy` output 1: not IDLE.

## Operation
- Reset values: state IDLE, `dir` = FROM_PORT, `to_port` = 0, `rsp_valid` = 0, `rsp_data` = 0, counter 0, `req_ready` = 1, `busy` = 0.
- All outputs are registered except `req_ready` and `busy`, which decode state.
- FSM states are IDLE, READ, DRIVE and RECOVER.
- IDLE:
  - A handshake (`req_valid & req_ready`) with `req_write = 0` goes to READ.
  - A handshake with `req_write = 1` goes to DRIVE, setting `dir` = TO_PORT and `to_port` = `req_data` on the same edge.
- READ:
  - Lasts WAIT_CYCLES+1 cycles with `dir` = FROM_PORT.
  - On the edge ending the last cycle, `rsp_data` captures `from_port`, `rsp_valid` goes high, and the state returns to IDLE.
- DRIVE:
  - Lasts WAIT_CYCLES+1 cycles with `dir` = TO_PORT and `to_port` stable.
  - On the final edge, `dir` returns to FROM_PORT and `to_port` is set to 0.
  - Next state is RECOVER, or IDLE with a `rsp_valid` pulse if TURN_CYCLES = 0.
- RECOVER:
  - Lasts TURN_CYCLES cycles with `dir` = FROM_PORT and `req_ready` = 0.
  - Then goes to IDLE with a one-cycle `rsp_valid` pulse (write acknowledge; `rsp_data` is unchanged).
- The down-counter is sized `$clog2(max(WAIT_CYCLES,TURN_CYCLES)+1)` (minimum 1 bit). It is loaded on state entry and exits at 0.
- A request presented in the same cycle as a `rsp_valid` pulse is accepted (IDLE), so back-to-back reads have no bubble.
- `req_data` and `req_write` are sampled only at the handshake; later changes are ignored.
- Reset mid-transaction: `dir` goes to FROM_PORT immediately (asynchronously) and the transaction is dropped. No `rsp_valid` is issued.

## Timing
- Read: handshake at edge E0; `rsp_valid` is high in the cycle after edge E0+WAIT_CYCLES+1. `rsp_data` is the value of `from_port` immediately before that edge.
- Write:
  - `dir` = TO_PORT for exactly WAIT_CYCLES+1 cycles starting the cycle after the handshake.
  - `rsp_valid` follows after TURN_CYCLES further cycles.
  - The next accept comes no earlier than the `rsp_valid` cycle.
- `dir` never changes between TO_PORT and FROM_PORT except on the DRIVE entry and exit edges.

## Configuration
- `PORT_BUS_SYNC_EN` defined:
  - `from_port` passes through a 2-flop synchronizer (reset 0) before use.
  - READ lasts WAIT_CYCLES+3 cycles, so read latency grows by 2 and the sample reflects the same bus window.
- Undefined: `from_port` is used directly, with the latencies as above.

## Structure
- Shared package `pocket_pkg`: existing `port_dir_e`, plus new `port_bus_state_e` (IDLE, READ, DRIVE, RECOVER).
- Sub-module `port_sync`: parameterised-width 2-flop synchronizer, instantiated only under `PORT_BUS_SYNC_EN`.
- The top level connects `dir`, `to_port` and `from_port` to a `port_if` instance.

## Test plan
- Reset: assert `reset_n` = 0 during a DRIVE → `dir` = FROM_PORT within the same cycle, `to_port` = 0, no `rsp_valid`; after release `req_ready` = 1.
- Read, defaults (W=2): `from_port` = 0xA5 held, read accepted at E0 → `rsp_valid` high in the cycle after E3, `rsp_data` = 0xA5, `dir` never TO_PORT.
- Write, defaults: `req_data` = 0x3C → `dir` = TO_PORT and `to_port` = 0x3C for exactly 3 cycles, then 1 RECOVER cycle, then `rsp_valid`; `req_ready` = 0 throughout.
- Back-to-back: write 0x11, then read with `req_valid` held high → the read is accepted in the write's `rsp_valid` cycle, with no TO_PORT overlap into the READ.
- TURN_CYCLES = 0, WAIT_CYCLES = 0: write then read → 1 DRIVE cycle, `rsp_valid` immediately after, read completes in 1 cycle plus the response cycle.
- `PORT_BUS_SYNC_EN` defined: `from_port` changes 0x00→0x5A two cycles before the sample point → `rsp_data` = 0x5A at 2-cycle-longer latency.

Source files
------------

// File: rtl/pocket_pkg.sv
// Shared types for the pocket port interface and its bus controller.
package pocket_pkg;

  typedef enum logic {
    FROM_PORT = 1'b0,
    TO_PORT   = 1'b1
  } port_dir_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    DRIVE   = 2'd2,
    RECOVER = 2'd3
  } port_bus_state_e;

  // Bits needed to hold the larger of two down-counter loads, never below 1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/port_if.sv
// Bidirectional port interface bundle: direction, outbound and inbound data.
interface port_if
  import pocket_pkg::*;
#(
  parameter int DATA_WIDTH = 8
);
  port_dir_e               dir;
  logic [DATA_WIDTH-1:0]   to_port;
  logic [DATA_WIDTH-1:0]   from_port;
endinterface

// File: rtl/port_sync.sv
// Parameterised-width two-flop synchronizer, reset to zero.
module port_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/port_bus_ctrl.sv
// Single-beat read/write bus cycle controller with wait states and turnaround.
// Optional PORT_BUS_SYNC_EN adds a 2-flop synchronizer on from_port.
//   state   | meaning
//   IDLE    | ready for a request, bus released
//   READ    | bus released, waiting to sample from_port
//   DRIVE   | FPGA drives to_port
//   RECOVER | turnaround gap before the write acknowledge
module port_bus_ctrl
  import pocket_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output port_dir_e             dir,
  output logic [DATA_WIDTH-1:0] to_port,
  input  logic [DATA_WIDTH-1:0] from_port,
  output logic                  busy
);

  port_if #(.DATA_WIDTH(DATA_WIDTH)) pif ();

  logic [DATA_WIDTH-1:0] from_use;

`ifdef PORT_BUS_SYNC_EN
  // Two extra read cycles so the sample reflects the same bus window.
  localparam int RD_LOAD = WAIT_CYCLES + 2;
  port_sync #(.WIDTH(DATA_WIDTH)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pif.from_port),
    .q       (from_use)
  );
`else
  localparam int RD_LOAD = WAIT_CYCLES;
  assign from_use = pif.from_port;
`endif

  localparam int WR_LOAD   = WAIT_CYCLES;
  localparam int TURN_LOAD = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;
  localparam int CNT_W     = cnt_width(RD_LOAD, TURN_CYCLES);

  port_bus_state_e       state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  port_dir_e             dir_q, dir_d;
  logic [DATA_WIDTH-1:0] to_q, to_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  assign pif.dir       = dir_q;
  assign pif.to_port   = to_q;
  assign pif.from_port = from_port;

  assign dir       = pif.dir;
  assign to_port   = pif.to_port;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dir_q       <= FROM_PORT;
      to_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      to_q        <= to_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    to_d        = to_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_write) begin
            state_d = DRIVE;
            cnt_d   = CNT_W'(WR_LOAD);
            dir_d   = TO_PORT;
            to_d    = req_data;
          end else begin
            state_d = READ;
            cnt_d   = CNT_W'(RD_LOAD);
          end
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = from_use;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          dir_d = FROM_PORT;
          to_d  = '0;
          if (TURN_CYCLES == 0) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = RECOVER;
            cnt_d   = CNT_W'(TURN_LOAD);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RECOVER: begin
        if (cnt_q == '0) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_port_bus_ctrl.sv
// Directed bench for port_bus_ctrl: defaults instance plus a WAIT=0/TURN=0 instance.
module tb_port_bus_ctrl;
  import pocket_pkg::*;

`ifdef PORT_BUS_SYNC_EN
  localparam int RD_EXTRA = 2;
`else
  localparam int RD_EXTRA = 0;
`endif
  localparam int W = 2;
  localparam int T = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       req_valid = 0, req_write = 0;
  logic [7:0] req_data = 0, from_port = 0;
  logic       req_ready, rsp_valid, busy;
  logic [7:0] rsp_data, to_port;
  port_dir_e  dir;

  logic       b_req_valid = 0, b_req_write = 0;
  logic [7:0] b_req_data = 0, b_from_port = 0;
  logic       b_req_ready, b_rsp_valid, b_busy;
  logic [7:0] b_rsp_data, b_to_port;
  port_dir_e  b_dir;

  port_bus_ctrl #(.DATA_WIDTH(8), .WAIT_CYCLES(W), .TURN_CYCLES(T)) dut_a (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .dir(dir), .to_port(to_port), .from_port(from_port),
    .busy(busy));

  port_bus_ctrl #(.DATA_WIDTH(8), .WAIT_CYCLES(0), .TURN_CYCLES(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_data(b_req_data), .rsp_valid(b_rsp_valid),
    .rsp_data(b_rsp_data), .dir(b_dir), .to_port(b_to_port), .from_port(b_from_port),
    .busy(b_busy));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int l;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_dir", 32'(dir), 32'(FROM_PORT));
    chk("rst_to_port", 32'(to_port), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Read with from_port held at 0xA5
    l = W + 1 + RD_EXTRA;
    from_port = 8'hA5;
    req_valid = 1; req_write = 0; req_data = 8'h00;
    @(negedge clk);
    req_valid = 0;
    for (int k = 0; k <= l; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("rd_rsp_valid_k%0d", k), 32'(rsp_valid), 32'(k == l));
      chk($sformatf("rd_dir_k%0d", k), 32'(dir), 32'(FROM_PORT));
      chk($sformatf("rd_ready_k%0d", k), 32'(req_ready), 32'(k == l));
    end
    chk("rd_data", 32'(rsp_data), 32'h A5);
    from_port = 8'h00;
    @(negedge clk);
    chk("rd_pulse_end", 32'(rsp_valid), 0);
    chk("rd_data_hold", 32'(rsp_data), 32'hA5);

    // Write 0x3C; later req_data change must be ignored
    l = W + 1 + T;
    req_valid = 1; req_write = 1; req_data = 8'h3C;
    @(negedge clk);
    req_valid = 0; req_data = 8'hFF; req_write = 0;
    for (int k = 0; k <= l; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("wr_dir_k%0d", k), 32'(dir), (k <= W) ? 32'(TO_PORT) : 32'(FROM_PORT));
      chk($sformatf("wr_to_port_k%0d", k), 32'(to_port), (k <= W) ? 32'h3C : 32'h0);
      chk($sformatf("wr_rsp_valid_k%0d", k), 32'(rsp_valid), 32'(k == l));
      chk($sformatf("wr_ready_k%0d", k), 32'(req_ready), 32'(k == l));
    end
    chk("wr_rsp_data_unchanged", 32'(rsp_data), 32'hA5);
    @(negedge clk);

    // Back-to-back: write 0x11 then read with req_valid held
    from_port = 8'h77;
    req_valid = 1; req_write = 1; req_data = 8'h11;
    @(negedge clk);
    req_write = 0;
    for (int k = 0; k <= W + 1 + T; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("b2b_wr_rsp_k%0d", k), 32'(rsp_valid), 32'(k == W + 1 + T));
    end
    @(negedge clk);
    req_valid = 0;
    l = W + 1 + RD_EXTRA;
    for (int k = 0; k <= l; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("b2b_rd_dir_k%0d", k), 32'(dir), 32'(FROM_PORT));
      chk($sformatf("b2b_rd_busy_k%0d", k), 32'(busy), 32'(k != l));
      chk($sformatf("b2b_rd_rsp_k%0d", k), 32'(rsp_valid), 32'(k == l));
    end
    chk("b2b_rd_data", 32'(rsp_data), 32'h77);
    @(negedge clk);

    // Reset in the middle of DRIVE
    req_valid = 1; req_write = 1; req_data = 8'h5C;
    @(negedge clk);
    req_valid = 0;
    chk("mid_drive_dir", 32'(dir), 32'(TO_PORT));
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_dir", 32'(dir), 32'(FROM_PORT));
    chk("async_rst_to_port", 32'(to_port), 0);
    chk("async_rst_rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("post_rst_ready", 32'(req_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_no_rsp_k%0d", k), 32'(rsp_valid), 0);
    end

    // WAIT=0, TURN=0 instance: write then read
    b_from_port = 8'hC3;
    b_req_valid = 1; b_req_write = 1; b_req_data = 8'h96;
    @(negedge clk);
    b_req_write = 0;
    chk("z_drive_dir", 32'(b_dir), 32'(TO_PORT));
    chk("z_drive_data", 32'(b_to_port), 32'h96);
    chk("z_drive_ready", 32'(b_req_ready), 0);
    @(negedge clk);
    chk("z_wr_rsp", 32'(b_rsp_valid), 1);
    chk("z_wr_dir_back", 32'(b_dir), 32'(FROM_PORT));
    chk("z_wr_to_port_zero", 32'(b_to_port), 0);
    chk("z_wr_ready", 32'(b_req_ready), 1);
    @(negedge clk);
    b_req_valid = 0;
    l = 1 + RD_EXTRA;
    for (int k = 0; k <= l; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("z_rd_rsp_k%0d", k), 32'(b_rsp_valid), 32'(k == l));
      chk($sformatf("z_rd_dir_k%0d", k), 32'(b_dir), 32'(FROM_PORT));
    end
    chk("z_rd_data", 32'(b_rsp_data), 32'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
